serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: diff = a - b - bin, computed LSB-first
//  one bit per clock through a single registered-borrow full-subtractor cell.
//  Inverse-direction companion to the full-adder datapath; sits behind a
//  valid/ready operand port and presents diff plus flags on a valid/ready result port.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (legal: 2..32)
//  CNT_W   $clog2(WIDTH+1)   bit-counter width (derived; do not override)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin (mod 2^WIDTH)
//  bout       out  1      unsigned borrow-out (a < b + bin)
//  ovf        out  1      signed overflow
//  zero       out  1      diff == 0
// BEHAVIOUR
//  Reset (async assert, sync deassert by system): state=IDLE; in_ready=1;
//   out_valid=0; diff/bout/ovf=0; zero=0; shift regs, borrow reg and counter cleared.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready: capture a, b into shift regs,
//   bin into borrow reg, count=0, latch a[WIDTH-1] and b[WIDTH-1] for ovf -> RUN.
//  RUN: in_ready=0. Per cycle: d=a0^b0^br; br'=(~a0&b0)|(~(a0^b0)&br);
//   d shifted into result MSB, result/a/b shift right 1, count++.
//   When count reaches WIDTH-1 on that cycle's edge -> DONE.
//  DONE: out_valid=1, in_ready=0; diff, bout=br, zero=(diff==0),
//   ovf=(a_msb!=b_msb)&&(diff[WIDTH-1]!=a_msb) stable until out_ready.
//   On out_valid&&out_ready -> IDLE; out_valid drops next cycle.
//  Latency: operand accept edge at cycle 0 -> out_valid high from cycle WIDTH.
//   Throughput: one op per WIDTH+2 cycles minimum (no overlap with DONE).
//  Handshake: out_valid never deasserts without out_ready; in_valid ignored
//   outside IDLE; inputs a/b/bin sampled only at accept edge.
//  Flags/diff registered in DONE only; held (not cleared) through IDLE until
//   overwritten by next completion. out_valid alone qualifies them.
//  Boundaries: a==b, bin=0 -> zero=1, bout=0; b=0, bin=0 -> diff=a;
//   0-0-1 -> all-ones, bout=1; ovf and bout independent.
//  Reset mid-RUN/DONE: abort, all state to reset values, no partial result visible.
// STRUCTURE
//  Shared package: state encoding (IDLE/RUN/DONE localparams), default WIDTH.
//  One sub-module: full_subtractor (a, b, bin -> d, bout), pure combinational,
//   gate-level xor/and/or like the full adder; borrow flop lives in parent.
// TESTING (WIDTH=8 unless noted; out_ready=1 unless noted)
//  1 a=5,b=3,bin=0 -> diff=0x02,bout=0,ovf=0,zero=0; out_valid exactly 8 cycles
//    after accept edge, in_ready low throughout RUN/DONE.
//  2 a=3,b=5 -> diff=0xFE,bout=1; a=0,b=0,bin=1 -> diff=0xFF,bout=1.
//  3 a=0x80,b=0x01 -> diff=0x7F,ovf=1,bout=0; a=0x7F,b=0xFF -> diff=0x80,ovf=1,bout=1.
//  4 a=b=0xA5 -> zero=1; hold out_ready=0 for 5 cycles -> out_valid and all
//    outputs stable; in_valid pulses meanwhile ignored.
//  5 rst_n low 3 cycles into RUN -> out_valid=0,in_ready=1 immediately; next op correct.
//  6 WIDTH=2 exhaustive: all a,b,bin (32 cases) vs reference model, back-to-back.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor: FSM encoding and
// the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter wide enough to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result channels of the serial subtractor.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready are
// both high; a source holding valid keeps its payload stable until that edge.
interface serial_subtractor_if import serial_subtractor_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from gate primitives; d = a ^ b ^ bin and the
// borrow is raised when a < b + bin for this bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_x_b;
  logic a_n;
  logic a_x_b_n;
  logic brw_gen;
  logic brw_prop;

  xor u_x0 (a_x_b, a, b);
  xor u_x1 (d, a_x_b, bin);

  not u_n0 (a_n, a);
  not u_n1 (a_x_b_n, a_x_b);
  and u_a0 (brw_gen, a_n, b);
  and u_a1 (brw_prop, a_x_b_n, bin);
  or  u_o0 (bout, brw_gen, brw_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock
// LSB-first, with a registered borrow and valid/ready operand/result ports.
module serial_subtractor import serial_subtractor_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus,
  output state_t               dbg_state
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               fs_d;
  logic               fs_bout;

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {fs_d, res_q[WIDTH-1:1]};
        br_d   = fs_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        // The last bit is processed on this edge, so the result registers are
        // loaded here and become visible together with out_valid.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = res_d;
          bout_d  = fs_bout;
          zero_d  = (res_d == '0);
          ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed WIDTH=8 vectors with hand-computed
// results, plus an exhaustive WIDTH=2 sweep against an arithmetic model.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  logic clk;
  logic rst_n;
  state_t dbg8;
  state_t dbg2;

  int tests = 0;
  int fails = 0;

  // {diff, bout, ovf, zero}
  logic [10:0] exp8_q[$];
  logic [4:0]  exp2_q[$];

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(2)) bus2 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus8),
    .dbg_state (dbg8)
  );

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2),
    .dbg_state (dbg2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [10:0] exp, input bit push);
    int n = 0;
    @(negedge clk);
    while (!bus8.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.in_ready) begin
      tests++;
      fails++;
      $display("FAIL drive8_timeout: in_ready=%0b, expected 1", bus8.in_ready);
    end
    bus8.a        = a;
    bus8.b        = b;
    bus8.bin      = bin;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    if (push) exp8_q.push_back(exp);
    #1 bus8.in_valid = 1'b0;
  endtask

  task automatic drive2(input logic [1:0] a, input logic [1:0] b, input logic bin);
    int n = 0;
    int ia, ib, sa, sb, sd;
    logic [4:0] e;
    @(negedge clk);
    while (!bus2.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus2.in_ready) begin
      tests++;
      fails++;
      $display("FAIL drive2_timeout: in_ready=%0b, expected 1", bus2.in_ready);
    end
    bus2.a        = a;
    bus2.b        = b;
    bus2.bin      = bin;
    bus2.in_valid = 1'b1;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 2) ? ia - 4 : ia;
    sb = (ib >= 2) ? ib - 4 : ib;
    sd = sa - sb - int'(bin);
    e[4:3] = 2'((ia - ib - int'(bin)) & 3);
    e[2]   = (ia < ib + int'(bin));
    e[1]   = (sd < -2) || (sd > 1);
    e[0]   = (((ia - ib - int'(bin)) & 3) == 0);
    @(posedge clk);
    exp2_q.push_back(e);
    #1 bus2.in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      if (exp8_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL result8_unexpected: diff=0x%0h with empty expected queue", bus8.diff);
      end else begin
        check("result8 {diff,bout,ovf,zero}",
              32'({bus8.diff, bus8.bout, bus8.ovf, bus8.zero}), 32'(exp8_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus2.out_valid && bus2.out_ready) begin
      if (exp2_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL result2_unexpected: diff=0x%0h with empty expected queue", bus2.diff);
      end else begin
        check("result2 {diff,bout,ovf,zero}",
              32'({bus2.diff, bus2.bout, bus2.ovf, bus2.zero}), 32'(exp2_q.pop_front()));
      end
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while ((exp8_q.size() != 0 || exp2_q.size() != 0 || dbg8 != IDLE) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int lat;
    bit ready_seen;
    int n;

    rst_n          = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.bin       = 1'b0;
    bus8.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.a         = '0;
    bus2.b         = '0;
    bus2.bin       = 1'b0;
    bus2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    check("reset_in_ready", 32'(bus8.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus8.out_valid), 32'd0);
    check("reset_flags {diff,bout,ovf,zero}",
          32'({bus8.diff, bus8.bout, bus8.ovf, bus8.zero}), 32'd0);
    check("reset_state", 32'(dbg8), 32'(IDLE));

    // 5 - 3: latency and in_ready low through RUN/DONE
    drive8(8'd5, 8'd3, 1'b0, {8'h02, 1'b0, 1'b0, 1'b0}, 1'b1);
    lat = 0;
    ready_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus8.in_ready) ready_seen = 1'b1;
      if (bus8.out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency_cycles", 32'(lat), 32'd8);
    check("in_ready_low_run_done", 32'(ready_seen), 32'd0);

    // Borrow, underflow, signed overflow and pass-through cases
    drive8(8'd3,  8'd5,  1'b0, {8'hFE, 1'b1, 1'b0, 1'b0}, 1'b1);
    drive8(8'h00, 8'h00, 1'b1, {8'hFF, 1'b1, 1'b0, 1'b0}, 1'b1);
    drive8(8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b1, 1'b0}, 1'b1);
    drive8(8'h7F, 8'hFF, 1'b0, {8'h80, 1'b1, 1'b1, 1'b0}, 1'b1);
    drive8(8'h3C, 8'h00, 1'b0, {8'h3C, 1'b0, 1'b0, 1'b0}, 1'b1);
    drive8(8'h80, 8'h00, 1'b1, {8'h7F, 1'b0, 1'b1, 1'b0}, 1'b1);
    drive8(8'h00, 8'h01, 1'b0, {8'hFF, 1'b1, 1'b0, 1'b0}, 1'b1);
    drain(200);

    // a == b with consumer stalled: outputs hold, in_valid ignored
    bus8.out_ready = 1'b0;
    drive8(8'hA5, 8'hA5, 1'b0, {8'h00, 1'b0, 1'b0, 1'b1}, 1'b1);
    n = 0;
    while (!bus8.out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_out_valid_reached", 32'(bus8.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus8.a        = 8'h11;
      bus8.b        = 8'h22;
      bus8.bin      = 1'b1;
      bus8.in_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      check("stall_out_valid_held", 32'(bus8.out_valid), 32'd1);
      check("stall_outputs_held {diff,bout,ovf,zero}",
            32'({bus8.diff, bus8.bout, bus8.ovf, bus8.zero}), 32'({8'h00, 1'b0, 1'b0, 1'b1}));
      check("stall_in_ready_low", 32'(bus8.in_ready), 32'd0);
    end
    @(negedge clk);
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("after_stall_idle", 32'(dbg8), 32'(IDLE));
    check("after_stall_out_valid", 32'(bus8.out_valid), 32'd0);

    // Reset three cycles into RUN, then a clean operation
    drive8(8'h10, 8'h20, 1'b1, {8'hEF, 1'b1, 1'b0, 1'b0}, 1'b1);
    drain(100);
    drive8(8'h55, 8'h0F, 1'b0, 11'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_out_valid", 32'(bus8.out_valid), 32'd0);
    check("midrun_reset_in_ready", 32'(bus8.in_ready), 32'd1);
    check("midrun_reset_diff", 32'(bus8.diff), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive8(8'd100, 8'd50, 1'b1, {8'h31, 1'b0, 1'b0, 1'b0}, 1'b1);
    drain(100);

    // WIDTH=2 exhaustive, back-to-back
    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      vv = 5'(v);
      drive2(vv[4:3], vv[2:1], vv[0]);
    end
    drain(400);

    check("queue8_empty", 32'(exp8_q.size()), 32'd0);
    check("queue2_empty", 32'(exp2_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
